alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU operand/opcode interface. Accepts one decoded-register RV32 instruction (R-type or I-type ALU op) with its source operands. It translates funct3/funct7/opcode into the 4-bit ALU opcode, drives registered operands into the combinational ALU, and captures the result and zero flag. It then presents them to register-file writeback over a valid/ready handshake. It sits between the register-read stage and the ALU in the core datapath.

Parameters:
WIDTH, 32, datapath width; immediates sign-extended to WIDTH; shift amount masked to $clog2(WIDTH) bits
CNT_W, 16, width of retired-op counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
instr_valid  input  1  instruction and operands valid
instr_ready  output  1  block can accept an instruction
instr  input  32  raw instruction word
rs1_data  input  WIDTH  source register 1 value
rs2_data  input  WIDTH  source register 2 value
alu_opA  output  WIDTH  registered operand A to ALU
alu_opB  output  WIDTH  registered operand B to ALU
alu_opcode  output  4  registered ALU opcode
alu_result  input  WIDTH  ALU combinational result
alu_zero  input  1  ALU zero flag
wb_valid  output  1  writeback data valid
wb_ready  input  1  writeback sink accepts
wb_rd  output  5  destination register index
wb_data  output  WIDTH  captured ALU result
wb_zero  output  1  captured zero flag
illegal  output  1  one-cycle pulse: accepted instruction not supported
retired  output  CNT_W  count of completed writebacks, wraps

Behaviour:
- Reset (synchronous, active-high): state=IDLE. alu_opA/alu_opB/alu_opcode/wb_data/wb_rd/wb_zero=0. wb_valid=0, illegal=0, retired=0. Reset mid-operation abandons the in-flight op with no writeback.
- ALU opcode encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0111.
- Decode, R-type (instr[6:0]=0110011):
  - f3=000: f7=0000000 ADD, f7=0100000 SUB.
  - f3=111 AND, f3=110 OR, f3=100 XOR (f7=0).
  - f3=001 SLL, f3=101 SRL (f7=0).
  - opB=rs2_data. For shifts, opB = rs2_data[$clog2(WIDTH)-1:0] zero-extended.
- Decode, I-type (instr[6:0]=0010011):
  - f3=000 ADD, 111 AND, 110 OR, 100 XOR. opB = sign-extended instr[31:20].
  - f3=001 SLL, f3=101 SRL, only when instr[31:25]=0. opB = instr[24:20] zero-extended.
- All other encodings are illegal, including SLT/SLTU/SRA and non-ALU major opcodes.
- opA=rs1_data always. wb_rd=instr[11:7]; rd=0 is still written back, and the register file discards it.
- FSM:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready:
    - legal: register opA/opB/opcode/rd, go to EXEC.
    - illegal: illegal=1 for the next cycle, ALU registers unchanged, stay IDLE.
  - EXEC (1 cycle): instr_ready=0. ALU settles on registered operands. At cycle end capture wb_data=alu_result and wb_zero=alu_zero, go to WB.
  - WB: wb_valid=1. wb_data/wb_rd/wb_zero held stable while wb_valid&&!wb_ready. On wb_ready: retired+=1 (wraps 2^CNT_W-1 to 0), go to IDLE; wb_valid low the next cycle.
- Latency: accepted at edge N; wb_valid high from the cycle after edge N+1. With wb_ready tied high, one instruction per 3 cycles.
- instr_ready is combinational from state only, with no dependence on instr_valid. instr_valid while not ready is ignored.
- alu_opA/alu_opB/alu_opcode hold their last values in WB and IDLE.

Test Plan:
- R-type SUB (f7=0100000, f3=000, rd=5), rs1=10, rs2=3, wb_ready=1 -> alu_opcode=0001; wb_valid 2 cycles after accept; wb_data=7, wb_rd=5, wb_zero=0, retired=1.
- ADDI imm=0xFFF (−1), rs1=1 -> opB=0xFFFFFFFF; wb_data=0, wb_zero=1.
- SLL R-type, rs1=1, rs2=0x00000024 -> opB=4 (masked); wb_data=0x10. SLLI with instr[31:25]=0100000 -> illegal pulse, no wb_valid, retired unchanged.
- wb_ready held 0 for 5 cycles after wb_valid -> wb_valid/wb_data stable, instr_ready=0, second instr_valid ignored. wb_ready=1 -> IDLE, next instruction accepted.
- retired preset via 65535 completions (CNT_W=16) -> next completion gives retired=0.
- rst asserted in EXEC -> next cycle IDLE, all outputs 0, no writeback for the in-flight op.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Decodes one RV32 R/I-type ALU instruction, drives registered operands to an external ALU and returns the result.
// Latency: accept -> EXEC -> WB (wb_valid one cycle after EXEC); no new instruction is taken until the writeback handshakes.
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_zero,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0111;

  localparam logic [6:0] MAJ_R = 7'b0110011;
  localparam logic [6:0] MAJ_I = 7'b0010011;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             dec_legal;
  logic [3:0]       dec_opcode;
  logic [WIDTH-1:0] dec_opb;
  logic [6:0]       f7;
  logic [2:0]       f3;
  logic             is_r;
  logic [WIDTH-1:0] imm_sext;
  logic             unused_rs1_field;

  assign f7               = instr[31:25];
  assign f3               = instr[14:12];
  assign is_r             = (instr[6:0] == MAJ_R);
  assign imm_sext         = {{(WIDTH-12){instr[31]}}, instr[31:20]};
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    dec_legal  = 1'b0;
    dec_opcode = OP_ADD;
    dec_opb    = is_r ? rs2_data : imm_sext;
    if (is_r || instr[6:0] == MAJ_I) begin
      case (f3)
        3'b000: begin
          // I-type has no SUB; only R-type looks at funct7 here
          if (!is_r || f7 == 7'b0000000) begin
            dec_legal  = 1'b1;
            dec_opcode = OP_ADD;
          end else if (f7 == 7'b0100000) begin
            dec_legal  = 1'b1;
            dec_opcode = OP_SUB;
          end
        end
        3'b111: begin dec_legal = !is_r || f7 == 7'b0; dec_opcode = OP_AND; end
        3'b110: begin dec_legal = !is_r || f7 == 7'b0; dec_opcode = OP_OR;  end
        3'b100: begin dec_legal = !is_r || f7 == 7'b0; dec_opcode = OP_XOR; end
        3'b001, 3'b101: begin
          dec_legal  = (f7 == 7'b0);
          dec_opcode = (f3 == 3'b001) ? OP_SLL : OP_SRL;
          dec_opb    = is_r ? {{(WIDTH-SH_W){1'b0}}, rs2_data[SH_W-1:0]}
                            : {{(WIDTH-5){1'b0}}, instr[24:20]};
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = (state == IDLE);
    wb_valid    = (state == WB);
    accept      = instr_valid && (state == IDLE);
    case (state)
      IDLE:    if (accept && dec_legal) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_opcode <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_zero    <= 1'b0;
      illegal    <= 1'b0;
      retired    <= '0;
    end else begin
      state   <= state_nxt;
      illegal <= accept && !dec_legal;
      if (accept && dec_legal) begin
        alu_opA    <= rs1_data;
        alu_opB    <= dec_opb;
        alu_opcode <= dec_opcode;
        wb_rd      <= instr[11:7];
      end
      if (state == EXEC) begin
        wb_data <= alu_result;
        wb_zero <= alu_zero;
      end
      if (wb_valid && wb_ready) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with an instruction-level reference model and a behavioural ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_opA, alu_opB;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;
  logic        illegal;
  logic [7:0]  retired;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_opA = '0, exp_opB = '0;
  logic [3:0]  exp_opc = '0;
  logic [7:0]  exp_ret = '0;

  alu_issue_ctrl #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_zero(wb_zero), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // External ALU behaviour
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      4'b0000: alu_result = alu_opA + alu_opB;
      4'b0001: alu_result = alu_opA - alu_opB;
      4'b0010: alu_result = alu_opA & alu_opB;
      4'b0011: alu_result = alu_opA | alu_opB;
      4'b0100: alu_result = alu_opA ^ alu_opB;
      4'b0101: alu_result = alu_opA << alu_opB[4:0];
      4'b0111: alu_result = alu_opA >> alu_opB[4:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  function automatic logic [31:0] r_instr(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_instr(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  // Architectural meaning of an instruction: legality, ALU opcode, operand B and final rd value
  function automatic void model(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2,
                                output bit legal, output logic [3:0] opc,
                                output logic [31:0] opb, output logic [31:0] res);
    logic [6:0]  maj, f7;
    logic [2:0]  f3;
    logic [31:0] imm;
    bit          r;
    maj = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
    imm = {{20{ins[31]}}, ins[31:20]};
    r = (maj == 7'h33);
    legal = 0; opc = 4'd0; opb = r ? rs2 : imm; res = '0;
    if (maj == 7'h33 || maj == 7'h13) begin
      case (f3)
        3'd0: if (!r || f7 == 7'h00) begin legal = 1; opc = 4'd0; end
              else if (f7 == 7'h20) begin legal = 1; opc = 4'd1; end
        3'd7: begin legal = !r || f7 == 0; opc = 4'd2; end
        3'd6: begin legal = !r || f7 == 0; opc = 4'd3; end
        3'd4: begin legal = !r || f7 == 0; opc = 4'd4; end
        3'd1, 3'd5: begin
          legal = (f7 == 0);
          opc = (f3 == 3'd1) ? 4'd5 : 4'd7;
          opb = r ? (rs2 % 32) : 32'(ins[24:20]);
        end
        default: legal = 0;
      endcase
    end
    case (opc)
      4'd0: res = rs1 + opb;
      4'd1: res = rs1 - opb;
      4'd2: res = rs1 & opb;
      4'd3: res = rs1 | opb;
      4'd4: res = rs1 ^ opb;
      4'd5: res = rs1 << opb;
      default: res = rs1 >> opb;
    endcase
  endfunction

  task automatic run_instr(input string name, input logic [31:0] ins, input logic [31:0] rs1,
                           input logic [31:0] rs2, input int stall);
    bit          legal;
    logic [3:0]  opc;
    logic [31:0] opb, res;
    model(ins, rs1, rs2, legal, opc, opb, res);
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle got %b exp 1", name, instr_ready); end
    instr = ins; rs1_data = rs1; rs2_data = rs2; instr_valid = 1'b1; wb_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
    if (!legal) begin
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL %s illegal_pulse got %b exp 1", name, illegal); end
      checks++; if (alu_opA !== exp_opA || alu_opB !== exp_opB || alu_opcode !== exp_opc) begin
        errors++; $display("FAIL %s alu_regs_held got %h/%h/%h exp %h/%h/%h", name, alu_opA, alu_opB, alu_opcode, exp_opA, exp_opB, exp_opc); end
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s ready_after_illegal got %b exp 1", name, instr_ready); end
      @(negedge clk);
      checks++; if (illegal !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL %s illegal_end got ill=%b wbv=%b exp 0/0", name, illegal, wb_valid); end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL %s retired_illegal got %0d exp %0d", name, retired, exp_ret); end
      return;
    end
    exp_opA = rs1; exp_opB = opb; exp_opc = opc;
    checks++; if (alu_opA !== exp_opA || alu_opB !== exp_opB || alu_opcode !== exp_opc) begin
      errors++; $display("FAIL %s alu_regs got %h/%h/%h exp %h/%h/%h", name, alu_opA, alu_opB, alu_opcode, exp_opA, exp_opB, exp_opc); end
    checks++; if (instr_ready !== 1'b0 || wb_valid !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL %s exec_flags got rdy=%b wbv=%b ill=%b exp 0/0/0", name, instr_ready, wb_valid, illegal); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s wb_valid got %b exp 1", name, wb_valid); end
    checks++; if (wb_data !== res || wb_rd !== ins[11:7] || wb_zero !== (res == 0)) begin
      errors++; $display("FAIL %s wb_payload got %h/%0d/%b exp %h/%0d/%b", name, wb_data, wb_rd, wb_zero, res, ins[11:7], res == 0); end
    for (int i = 0; i < stall; i++) begin
      instr = i_instr(12'h123, 3'b000, 5'd9); rs1_data = ~rs1; instr_valid = 1'b1;
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1 || wb_data !== res || wb_rd !== ins[11:7] || instr_ready !== 1'b0) begin
        errors++; $display("FAIL %s stall_hold got v=%b d=%h rd=%0d rdy=%b exp 1/%h/%0d/0", name, wb_valid, wb_data, wb_rd, instr_ready, res, ins[11:7]); end
    end
    instr_valid = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    exp_ret = exp_ret + 8'd1;
    checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL %s back_idle got wbv=%b rdy=%b exp 0/1", name, wb_valid, instr_ready); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL %s retired got %0d exp %0d", name, retired, exp_ret); end
    checks++; if (alu_opA !== exp_opA) begin errors++; $display("FAIL %s ignored_instr got opA %h exp %h", name, alu_opA, exp_opA); end
  endtask

  // Continuous issue with wb_ready high: expect one completion every 3 cycles
  task automatic stream(input string name, input int n);
    int cnt = 0;
    instr = r_instr(7'h00, 3'b000, 5'd3); rs1_data = 32'd40; rs2_data = 32'd2;
    instr_valid = 1'b1; wb_ready = 1'b1;
    repeat (3 * n) begin
      @(negedge clk);
      if (wb_valid && wb_ready) begin
        cnt++;
        checks++; if (wb_data !== 32'd42) begin errors++; $display("FAIL %s stream_data got %h exp 2a", name, wb_data); end
      end
    end
    instr_valid = 1'b0; wb_ready = 1'b0;
    exp_opA = 32'd40; exp_opB = 32'd2; exp_opc = 4'd0;
    exp_ret = exp_ret + 8'(n);
    checks++; if (cnt != n) begin errors++; $display("FAIL %s throughput got %0d exp %0d", name, cnt, n); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL %s stream_retired got %0d exp %0d", name, retired, exp_ret); end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; wb_ready = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (alu_opA !== 0 || alu_opB !== 0 || alu_opcode !== 0) begin errors++; $display("FAIL reset alu_regs got %h/%h/%h exp 0", alu_opA, alu_opB, alu_opcode); end
    checks++; if (wb_data !== 0 || wb_rd !== 0 || wb_zero !== 0 || wb_valid !== 0) begin errors++; $display("FAIL reset wb got %h/%0d/%b/%b exp 0", wb_data, wb_rd, wb_zero, wb_valid); end
    checks++; if (illegal !== 0 || retired !== 0 || instr_ready !== 1) begin errors++; $display("FAIL reset misc got ill=%b ret=%0d rdy=%b exp 0/0/1", illegal, retired, instr_ready); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_instr("sub", r_instr(7'h20, 3'b000, 5'd5), 32'd10, 32'd3, 0);
    checks++; if (wb_data !== 32'd7 || retired !== 8'd1) begin errors++; $display("FAIL sub_const got %h ret %0d exp 7 ret 1", wb_data, retired); end
    run_instr("addi_m1", i_instr(12'hFFF, 3'b000, 5'd6), 32'd1, 32'h55, 0);
    checks++; if (alu_opB !== 32'hFFFF_FFFF || wb_zero !== 1'b1) begin errors++; $display("FAIL addi_const got opB %h zero %b exp ffffffff 1", alu_opB, wb_zero); end
    run_instr("sll_mask", r_instr(7'h00, 3'b001, 5'd7), 32'd1, 32'h24, 0);
    checks++; if (alu_opB !== 32'd4 || wb_data !== 32'h10) begin errors++; $display("FAIL sll_const got opB %h data %h exp 4 10", alu_opB, wb_data); end
    run_instr("slli_bad", i_instr({7'h20, 5'd3}, 3'b001, 5'd8), 32'd1, 32'd0, 0);
    run_instr("srai_bad", i_instr({7'h20, 5'd3}, 3'b101, 5'd8), 32'd1, 32'd0, 0);
    run_instr("slt_bad", r_instr(7'h00, 3'b010, 5'd8), 32'd1, 32'd2, 0);
    run_instr("load_bad", {12'h004, 5'd1, 3'b010, 5'd8, 7'b0000011}, 32'd1, 32'd2, 0);
    run_instr("srli", i_instr({7'h00, 5'd4}, 3'b101, 5'd0), 32'h8000_0000, 32'd9, 0);
    run_instr("stall", r_instr(7'h00, 3'b100, 5'd31), 32'hF0F0_1234, 32'h0FF0_1234, 5);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  f7;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: f7 = 7'h20;
        1: f7 = 7'($urandom);
        default: f7 = 7'h00;
      endcase
      ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'b0010011};
      case ($urandom_range(0, 3))
        0, 1: ins[6:0] = 7'b0110011;
        2: ins[6:0] = 7'b0010011;
        default: ins[6:0] = 7'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) run_instr("rand_eq", ins, 32'h1234_5678, 32'h1234_5678, $urandom_range(0, 2));
      else run_instr("rand", ins, $urandom, $urandom, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    stream("b2b", 10);
  endtask

  task automatic test_retired_wrap();
    int n;
    n = 255 - int'(exp_ret);
    if (n > 0) stream("wrap_fill", n);
    checks++; if (retired !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d exp 255", retired); end
    stream("wrap", 1);
    checks++; if (retired !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", retired); end
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    instr = r_instr(7'h00, 3'b110, 5'd12); rs1_data = 32'hA5; rs2_data = 32'h5A; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_exec in_exec got rdy=%b exp 0", instr_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_opA = '0; exp_opB = '0; exp_opc = '0; exp_ret = '0;
    checks++; if (alu_opA !== 0 || alu_opB !== 0 || alu_opcode !== 0 || wb_data !== 0 || wb_rd !== 0) begin
      errors++; $display("FAIL rst_exec regs got %h/%h/%h/%h/%0d exp 0", alu_opA, alu_opB, alu_opcode, wb_data, wb_rd); end
    checks++; if (instr_ready !== 1'b1 || retired !== 0 || illegal !== 0) begin
      errors++; $display("FAIL rst_exec state got rdy=%b ret=%0d ill=%b exp 1/0/0", instr_ready, retired, illegal); end
    wb_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_exec no_wb got %b exp 0", wb_valid); end
    end
    wb_ready = 1'b0;
    run_instr("after_rst", i_instr(12'h00F, 3'b111, 5'd3), 32'hFF, 32'd0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_retired_wrap();
    test_reset_in_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
